// File: rtl/smem_line_master_if.sv
// smem_line_master_if: SMEM AXI4 channel bundle between the line master and the host-memory slave.
interface smem_line_master_if;
  logic [63:0] SMEM_araddr;
  logic [1:0]  SMEM_arburst;
  logic [3:0]  SMEM_arcache;
  logic        SMEM_arid;
  logic [7:0]  SMEM_arlen;
  logic        SMEM_arlock;
  logic [2:0]  SMEM_arprot;
  logic [3:0]  SMEM_arqos;
  logic [2:0]  SMEM_arsize;
  logic        SMEM_arvalid;
  logic        SMEM_arready;
  logic [63:0] SMEM_awaddr;
  logic [1:0]  SMEM_awburst;
  logic [3:0]  SMEM_awcache;
  logic        SMEM_awid;
  logic [7:0]  SMEM_awlen;
  logic        SMEM_awlock;
  logic [2:0]  SMEM_awprot;
  logic [3:0]  SMEM_awqos;
  logic [2:0]  SMEM_awsize;
  logic        SMEM_awvalid;
  logic        SMEM_awready;
  logic [63:0] SMEM_wdata;
  logic [7:0]  SMEM_wstrb;
  logic        SMEM_wlast;
  logic        SMEM_wvalid;
  logic        SMEM_wready;
  logic        SMEM_bid;
  logic [1:0]  SMEM_bresp;
  logic        SMEM_bvalid;
  logic        SMEM_bready;
  logic [63:0] SMEM_rdata;
  logic        SMEM_rid;
  logic [1:0]  SMEM_rresp;
  logic        SMEM_rlast;
  logic        SMEM_rvalid;
  logic        SMEM_rready;
  modport master (
    output SMEM_araddr, SMEM_arburst, SMEM_arcache, SMEM_arid, SMEM_arlen, SMEM_arlock,
           SMEM_arprot, SMEM_arqos, SMEM_arsize, SMEM_arvalid,
           SMEM_awaddr, SMEM_awburst, SMEM_awcache, SMEM_awid, SMEM_awlen, SMEM_awlock,
           SMEM_awprot, SMEM_awqos, SMEM_awsize, SMEM_awvalid,
           SMEM_wdata, SMEM_wstrb, SMEM_wlast, SMEM_wvalid, SMEM_bready, SMEM_rready,
    input  SMEM_arready, SMEM_awready, SMEM_wready, SMEM_bid, SMEM_bresp, SMEM_bvalid,
           SMEM_rdata, SMEM_rid, SMEM_rresp, SMEM_rlast, SMEM_rvalid
  );
  modport slave (
    input  SMEM_araddr, SMEM_arburst, SMEM_arcache, SMEM_arid, SMEM_arlen, SMEM_arlock,
           SMEM_arprot, SMEM_arqos, SMEM_arsize, SMEM_arvalid,
           SMEM_awaddr, SMEM_awburst, SMEM_awcache, SMEM_awid, SMEM_awlen, SMEM_awlock,
           SMEM_awprot, SMEM_awqos, SMEM_awsize, SMEM_awvalid,
           SMEM_wdata, SMEM_wstrb, SMEM_wlast, SMEM_wvalid, SMEM_bready, SMEM_rready,
    output SMEM_arready, SMEM_awready, SMEM_wready, SMEM_bid, SMEM_bresp, SMEM_bvalid,
           SMEM_rdata, SMEM_rid, SMEM_rresp, SMEM_rlast, SMEM_rvalid
  );
endinterface

// File: rtl/smem_line_master.sv
// smem_line_master: turns single cache-line requests into 8-beat x 64-bit AXI4 INCR bursts on SMEM.
// Optional watchdog enabled by defining SMEM_LINE_MASTER_TIMEOUT_EN.
module smem_line_master #(
  parameter int BEATS = 8,
  parameter int LINE_W = BEATS * 64,
  parameter int AXI_ID = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [63:0]          req_addr_i,
  input  logic [LINE_W-1:0]    req_wdata_i,
  input  logic [BEATS*8-1:0]   req_wstrb_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [LINE_W-1:0]    resp_rdata_o,
  output logic                 resp_err_o,
  smem_line_master_if.master   m
);
  localparam int CW = $clog2(BEATS);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RESP} state_e;
  state_e              state_q, state_d;
  logic [63:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [BEATS*8-1:0]  wstrb_q, wstrb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d, last, unused;
  assign last = cnt_q == CW'(BEATS - 1);
  assign unused = ^{req_addr_i[5:0], m.SMEM_bid, m.SMEM_rid, 32'(TIMEOUT_CYCLES)};
`ifdef SMEM_LINE_MASTER_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  logic        busy, hs, tmo;
  assign busy = state_q inside {AR, R, AW, W, B};
  assign hs = (m.SMEM_arvalid && m.SMEM_arready) || (m.SMEM_rvalid && m.SMEM_rready) ||
              (m.SMEM_awvalid && m.SMEM_awready) || (m.SMEM_wvalid && m.SMEM_wready) ||
              (m.SMEM_bvalid && m.SMEM_bready);
  assign tmo = busy && !hs && to_q == 32'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef SMEM_LINE_MASTER_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef SMEM_LINE_MASTER_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d  = {req_addr_i[63:6], 6'd0};
        wdata_d = req_wdata_i;
        wstrb_d = req_wstrb_i;
        err_d   = 1'b0;
        cnt_d   = '0;
        rdata_d = req_write_i ? rdata_q : '0;
        state_d = req_write_i ? AW : AR;
      end
      AR: state_d = m.SMEM_arready ? R : AR;
      R: if (m.SMEM_rvalid) begin
        // the beat counter alone ends the burst; a misplaced rlast only flags an error
        rdata_d[{cnt_q, 6'd0} +: 64] = m.SMEM_rdata;
        err_d   = err_q | (m.SMEM_rresp != 2'd0) | (m.SMEM_rlast != last);
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? RESP : R;
      end
      AW: state_d = m.SMEM_awready ? W : AW;
      W: if (m.SMEM_wready) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? B : W;
      end
      B: if (m.SMEM_bvalid) begin
        err_d   = err_q | (m.SMEM_bresp != 2'd0);
        state_d = RESP;
      end
      RESP: state_d = resp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
`ifdef SMEM_LINE_MASTER_TIMEOUT_EN
    if (tmo) begin
      state_d = RESP;
      err_d   = 1'b1;
    end
    to_d = (!busy || hs || state_d != state_q) ? '0 : to_q + 1'b1;
`endif
  end
  always_comb begin
    req_ready_o    = resetn && state_q == IDLE;
    resp_valid_o   = state_q == RESP;
    resp_rdata_o   = rdata_q;
    resp_err_o     = err_q;
    m.SMEM_araddr  = addr_q;
    m.SMEM_arburst = 2'b01;
    m.SMEM_arcache = 4'b0011;
    m.SMEM_arid    = 1'(AXI_ID);
    m.SMEM_arlen   = 8'(BEATS - 1);
    m.SMEM_arlock  = 1'b0;
    m.SMEM_arprot  = 3'd0;
    m.SMEM_arqos   = 4'd0;
    m.SMEM_arsize  = 3'd3;
    m.SMEM_arvalid = state_q == AR;
    m.SMEM_awaddr  = addr_q;
    m.SMEM_awburst = 2'b01;
    m.SMEM_awcache = 4'b0011;
    m.SMEM_awid    = 1'(AXI_ID);
    m.SMEM_awlen   = 8'(BEATS - 1);
    m.SMEM_awlock  = 1'b0;
    m.SMEM_awprot  = 3'd0;
    m.SMEM_awqos   = 4'd0;
    m.SMEM_awsize  = 3'd3;
    m.SMEM_awvalid = state_q == AW;
    m.SMEM_wdata   = wdata_q[{cnt_q, 6'd0} +: 64];
    m.SMEM_wstrb   = wstrb_q[{cnt_q, 3'd0} +: 8];
    m.SMEM_wlast   = state_q == W && last;
    m.SMEM_wvalid  = state_q == W;
    m.SMEM_bready  = state_q == B;
    m.SMEM_rready  = state_q == R;
  end
endmodule

// File: tb/tb_smem_line_master.sv
// tb_smem_line_master: directed bench for smem_line_master with an in-line SMEM slave.
module tb_smem_line_master;
`ifdef SMEM_LINE_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_err;
  logic [63:0] req_addr = '0, req_wstrb = '0;
  logic [511:0] req_wdata = '0, resp_rdata;
  int passed = 0, total = 0;
  int lat, rcount, wcount, wlast_n, wlast_at;
  bit early_w;
  logic [63:0] got_araddr, got_awaddr, wstr;
  logic [7:0] got_arlen, got_awlen;
  logic [17:0] got_arc, got_awc;
  logic [511:0] wline;
  localparam logic [17:0] AXC = {3'd3, 2'b01, 4'b0011, 1'b0, 3'd0, 4'd0, 1'b0};

  smem_line_master_if sm();
  smem_line_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .m(sm)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic slave_idle();
    sm.SMEM_arready = 0; sm.SMEM_awready = 0; sm.SMEM_wready = 0;
    sm.SMEM_bvalid = 0; sm.SMEM_bresp = 0; sm.SMEM_bid = 0;
    sm.SMEM_rvalid = 0; sm.SMEM_rdata = 0; sm.SMEM_rid = 0; sm.SMEM_rresp = 0; sm.SMEM_rlast = 0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // issues one request at a negedge in IDLE and plays the slave until resp_valid
  task automatic txn(input logic wr, input logic [63:0] a, input logic [511:0] wd, input logic [63:0] ws,
                     input int eb, input logic [1:0] br, input bit wt);
    bit tog, aw_done;
    tog = 1'b1; aw_done = 1'b0;
    rcount = 0; wcount = 0; wlast_n = 0; wlast_at = -1; early_w = 0; lat = -1; wline = '0; wstr = '0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      slave_idle();
      if (resp_valid) begin
        lat = c;
        break;
      end
      if (sm.SMEM_arvalid) begin
        sm.SMEM_arready = 1; got_araddr = sm.SMEM_araddr; got_arlen = sm.SMEM_arlen;
        got_arc = {sm.SMEM_arsize, sm.SMEM_arburst, sm.SMEM_arcache, sm.SMEM_arlock, sm.SMEM_arprot, sm.SMEM_arqos, sm.SMEM_arid};
      end
      if (sm.SMEM_awvalid) begin
        sm.SMEM_awready = 1; got_awaddr = sm.SMEM_awaddr; got_awlen = sm.SMEM_awlen; aw_done = 1'b1;
        got_awc = {sm.SMEM_awsize, sm.SMEM_awburst, sm.SMEM_awcache, sm.SMEM_awlock, sm.SMEM_awprot, sm.SMEM_awqos, sm.SMEM_awid};
      end
      if (sm.SMEM_wvalid) begin
        if (!aw_done || sm.SMEM_awvalid) early_w = 1;
        sm.SMEM_wready = wt ? tog : 1'b1;
        if (sm.SMEM_wready) begin
          if (wcount < 8) begin
            wline[wcount*64 +: 64] = sm.SMEM_wdata;
            wstr[wcount*8 +: 8] = sm.SMEM_wstrb;
          end
          if (sm.SMEM_wlast) begin
            wlast_n++;
            wlast_at = wcount;
          end
          wcount++;
        end
      end
      tog = ~tog;
      if (sm.SMEM_rready) begin
        sm.SMEM_rvalid = 1; sm.SMEM_rdata = 64'h10 + 64'(rcount);
        sm.SMEM_rresp = (rcount == eb) ? 2'd2 : 2'd0; sm.SMEM_rlast = rcount == 7;
        rcount++;
      end
      if (sm.SMEM_bready) begin
        sm.SMEM_bvalid = 1; sm.SMEM_bresp = br;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [511:0] rline, wexp;
    for (int k = 0; k < 8; k++) begin
      rline[k*64 +: 64] = 64'h10 + 64'(k);
      wexp[k*64 +: 64] = 64'hA0 + 64'(k);
    end
    slave_idle();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_valids", {sm.SMEM_arvalid, sm.SMEM_awvalid, sm.SMEM_wvalid, sm.SMEM_rready, sm.SMEM_bready}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    txn(1'b0, 64'h1_2000_0040, '0, '0, -1, 2'd0, 1'b0);
    chk("rd_araddr", got_araddr, 64'h1_2000_0040);
    chk("rd_arlen", got_arlen, 8'd7);
    chk("rd_arconst", got_arc, AXC);
    chk("rd_latency", lat, 10);
    chk("rd_beats", rcount, 8);
    chk("rd_data", resp_rdata, rline);
    chk("rd_err", resp_err, 0);
    finish_resp();
    chk("rd_done_valid", resp_valid, 0);
    chk("rd_done_ready", req_ready, 1);

    txn(1'b1, 64'h1_2000_0080, wexp, '1, -1, 2'd0, 1'b1);
    chk("wr_done", lat > 0, 1);
    chk("wr_awaddr", got_awaddr, 64'h1_2000_0080);
    chk("wr_awlen", got_awlen, 8'd7);
    chk("wr_awconst", got_awc, AXC);
    chk("wr_beats", wcount, 8);
    chk("wr_data", wline, wexp);
    chk("wr_strb", wstr, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_wlast_count", wlast_n, 1);
    chk("wr_wlast_beat", wlast_at, 7);
    chk("wr_aw_before_w", early_w, 0);
    chk("wr_err", resp_err, 0);
    chk("wr_rdata_held", resp_rdata, rline);
    finish_resp();

    txn(1'b0, 64'h1_2000_00FF, '0, '0, -1, 2'd0, 1'b0);
    chk("align_araddr", got_araddr, 64'h1_2000_00C0);
    chk("align_err", resp_err, 0);
    finish_resp();

    txn(1'b0, 64'h1_2000_0100, '0, '0, 3, 2'd0, 1'b0);
    chk("rresp_beats", rcount, 8);
    chk("rresp_err", resp_err, 1);
    chk("rresp_data", resp_rdata, rline);
    finish_resp();

    txn(1'b1, 64'h1_2000_0140, ~wexp, 64'h0F0F_0F0F_F0F0_F0F0, -1, 2'd2, 1'b0);
    chk("bresp_latency", lat, 11);
    chk("bresp_data", wline, ~wexp);
    chk("bresp_strb", wstr, 64'h0F0F_0F0F_F0F0_F0F0);
    chk("bresp_err", resp_err, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h1_2000_0300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rline);
      chk("hold_err", resp_err, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_no_ar", sm.SMEM_arvalid, 0);
    end
    req_valid = 1'b0;
    finish_resp();
    chk("hold_after_ready", req_ready, 1);
    chk("hold_after_valid", resp_valid, 0);

    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h1_2000_0180;
    @(negedge clk);
    req_valid = 1'b0;
    sm.SMEM_arready = 1;
    @(negedge clk);
    slave_idle();
    for (int b = 0; b < 4; b++) begin
      sm.SMEM_rvalid = 1; sm.SMEM_rdata = 64'h10 + 64'(b);
      @(negedge clk);
    end
    chk("mid_rready", sm.SMEM_rready, 1);
    sm.SMEM_rvalid = 1; sm.SMEM_rdata = 64'h14;
    #2 resetn = 1'b0;
    #1;
    chk("arst_valids", {sm.SMEM_arvalid, sm.SMEM_awvalid, sm.SMEM_wvalid, sm.SMEM_rready, sm.SMEM_bready, resp_valid}, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_rdata", resp_rdata, 0);
    slave_idle();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", req_ready, 1);
    txn(1'b0, 64'h1_2000_01C0, '0, '0, -1, 2'd0, 1'b0);
    chk("arst_next_latency", lat, 10);
    chk("arst_next_data", resp_rdata, rline);
    chk("arst_next_err", resp_err, 0);
    finish_resp();

`ifdef SMEM_LINE_MASTER_TIMEOUT_EN
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h1_2000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk("to_latency", lat, 17);
    chk("to_err", resp_err, 1);
    chk("to_rdata", resp_rdata, 0);
    chk("to_arvalid", sm.SMEM_arvalid, 0);
    finish_resp();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
